// File: rtl/timer_pkg.sv
// Shared opcodes, state encoding and error codes
// for the timer programming host.
package timer_pkg;

  localparam logic [1:0] OP_RUN   = 2'b00;
  localparam logic [1:0] OP_ABORT = 2'b01;
  localparam logic [1:0] OP_ACK   = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_START = 3'd4;
  localparam logic [2:0] ST_RUN   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_CLEAR     = ST_CLEAR,
    S_WAIT_FREE = ST_WAIT,
    S_WRITE     = ST_WRITE,
    S_START     = ST_START,
    S_RUN       = ST_RUN,
    S_DONE      = ST_DONE
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ZERO  = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  localparam int MAX_SEC_MIN = 59;

endpackage

// File: rtl/timer_cmd_chk.sv
// Combinational validator for a RUN request.
// Range errors outrank the up-count zero-field error.
module timer_cmd_chk
  import timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             up,
  input  logic [WIDTH-1:0] sec,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] hour,
  output logic             ok,
  output logic [1:0]       err_code
);

  localparam logic [WIDTH-1:0] LIM =
    WIDTH'(MAX_SEC_MIN);

  logic range_bad;
  logic zero_bad;

  // Classify the request; first failing rule wins
  always_comb begin
    range_bad = (sec > LIM) || (min > LIM);
    zero_bad  = up && ((sec == '0) ||
                       (min == '0) ||
                       (hour == '0));
    ok        = 1'b1;
    err_code  = ERR_NONE;
    if (range_bad) begin
      ok       = 1'b0;
      err_code = ERR_RANGE;
    end else if (zero_bad) begin
      ok       = 1'b0;
      err_code = ERR_ZERO;
    end
  end

endmodule

// File: rtl/timer_host.sv
// Command front end for one timer: sequences
// clear/write/start and tracks alarms and errors.
module timer_host
  import timer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             cut_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_up,
  input  logic [WIDTH-1:0] cmd_sec,
  input  logic [WIDTH-1:0] cmd_min,
  input  logic [WIDTH-1:0] cmd_hour,
  output logic             tmr_cut_n,
  output logic             tmr_write,
  output logic             tmr_start,
  output logic             tmr_up,
  output logic [WIDTH-1:0] tmr_insec,
  output logic [WIDTH-1:0] tmr_inmin,
  output logic [WIDTH-1:0] tmr_inhour,
  input  logic             tmr_buzy_n,
  input  logic             tmr_alarm,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] alarm_cnt
);

  localparam logic [7:0] WAIT_LAST =
    8'(WAIT_MAX - 1);

  state_e           state_q, state_d;
  logic             abort_q, abort_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;
  logic [CNT_W-1:0] acnt_q, acnt_d;
  logic             up_q, up_d;
  logic [WIDTH-1:0] sec_q, sec_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] hour_q, hour_d;

  logic             acc;
  logic             load;
  logic             chk_ok;
  logic [1:0]       chk_code;

  timer_cmd_chk #(
    .WIDTH (WIDTH)
  ) u_chk (
    .up       (cmd_up),
    .sec      (cmd_sec),
    .min      (cmd_min),
    .hour     (cmd_hour),
    .ok       (chk_ok),
    .err_code (chk_code)
  );

  assign acc = cmd_valid && cmd_ready;

  // Next-state, status and accept-register update
  always_comb begin
    state_d = state_q;
    abort_d = abort_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    code_d  = code_q;
    acnt_d  = acnt_q;
    up_d    = up_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    load    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (acc) begin
          unique case (cmd_op)
            OP_RUN: begin
              if (chk_ok) begin
                load    = 1'b1;
                state_d = S_CLEAR;
                abort_d = 1'b0;
                err_d   = 1'b0;
                code_d  = ERR_NONE;
              end else begin
                err_d  = 1'b1;
                code_d = chk_code;
              end
            end
            OP_ABORT: begin
              err_d  = 1'b0;
              code_d = ERR_NONE;
              if (state_q == S_DONE) begin
                state_d = S_CLEAR;
                abort_d = 1'b1;
              end
            end
            OP_ACK: begin
              err_d   = 1'b0;
              code_d  = ERR_NONE;
              state_d = S_IDLE;
            end
            OP_RSVD: begin
              err_d  = 1'b1;
              code_d = ERR_TMO;
            end
          endcase
        end
      end

      S_CLEAR: begin
        wcnt_d  = '0;
        state_d = abort_q ? S_IDLE
                          : S_WAIT_FREE;
      end

      S_WAIT_FREE: begin
        if (tmr_buzy_n) begin
          state_d = S_WRITE;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TMO;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end

      S_WRITE: state_d = S_START;

      S_START: state_d = S_RUN;

      S_RUN: begin
        if (acc && (cmd_op == OP_ABORT)) begin
          state_d = S_CLEAR;
          abort_d = 1'b1;
          err_d   = 1'b0;
          code_d  = ERR_NONE;
        end else begin
          if (acc) begin
            err_d  = 1'b1;
            code_d = ERR_TMO;
          end
          if (tmr_alarm) begin
            state_d = S_DONE;
            if (acnt_q != '1) begin
              acnt_d = acnt_q + 1'b1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load) begin
      up_d   = cmd_up;
      sec_d  = cmd_sec;
      min_d  = cmd_min;
      hour_d = cmd_hour;
    end
  end

  // State and status registers
  always_ff @(posedge clk or negedge cut_n) begin
    if (!cut_n) begin
      state_q <= S_IDLE;
      abort_q <= 1'b0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      acnt_q  <= '0;
      up_q    <= 1'b0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
      acnt_q  <= acnt_d;
      up_q    <= up_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) ||
                     (state_q == S_RUN)  ||
                     (state_q == S_DONE);

  assign busy = (state_q == S_CLEAR)     ||
                (state_q == S_WAIT_FREE) ||
                (state_q == S_WRITE)     ||
                (state_q == S_START)     ||
                (state_q == S_RUN);

  assign done      = (state_q == S_DONE);
  assign tmr_cut_n = (state_q == S_CLEAR);
  assign tmr_write = (state_q == S_WRITE);
  assign tmr_start = (state_q == S_START);

  assign tmr_up     = up_q;
  assign tmr_insec  = sec_q;
  assign tmr_inmin  = min_q;
  assign tmr_inhour = hour_q;
  assign err        = err_q;
  assign err_code   = code_q;
  assign alarm_cnt  = acnt_q;

endmodule

// File: tb/tb_timer_host.sv
// Directed plus random bench for timer_host
// against a transaction-level reference model.
module tb_timer_host;

  localparam int W  = 16;
  localparam int CW = 8;
  localparam int WM = 15;

  logic          clk = 1'b0;
  logic          cut_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic          cmd_up;
  logic [W-1:0]  cmd_sec;
  logic [W-1:0]  cmd_min;
  logic [W-1:0]  cmd_hour;
  logic          tmr_cut_n;
  logic          tmr_write;
  logic          tmr_start;
  logic          tmr_up;
  logic [W-1:0]  tmr_insec;
  logic [W-1:0]  tmr_inmin;
  logic [W-1:0]  tmr_inhour;
  logic          tmr_buzy_n;
  logic          tmr_alarm;
  logic          busy;
  logic          done;
  logic          err;
  logic [1:0]    err_code;
  logic [CW-1:0] alarm_cnt;

  timer_host #(
    .WIDTH    (W),
    .WAIT_MAX (WM),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .cut_n      (cut_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_up     (cmd_up),
    .cmd_sec    (cmd_sec),
    .cmd_min    (cmd_min),
    .cmd_hour   (cmd_hour),
    .tmr_cut_n  (tmr_cut_n),
    .tmr_write  (tmr_write),
    .tmr_start  (tmr_start),
    .tmr_up     (tmr_up),
    .tmr_insec  (tmr_insec),
    .tmr_inmin  (tmr_inmin),
    .tmr_inhour (tmr_inhour),
    .tmr_buzy_n (tmr_buzy_n),
    .tmr_alarm  (tmr_alarm),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .alarm_cnt  (alarm_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: 0 idle, 1 running, 2 done
  int m_st;
  int m_acnt;
  int m_err;
  int m_code;
  int m_up;
  int m_sec;
  int m_min;
  int m_hour;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_code(
    input int up, input int s,
    input int m, input int h);
    if (s > 59 || m > 59) return 1;
    if (up != 0 && (s == 0 || m == 0 || h == 0))
      return 2;
    return 0;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic send(input logic [1:0] op,
                      input int up, input int s,
                      input int m, input int h);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_up    = (up != 0);
    cmd_sec   = W'(s);
    cmd_min   = W'(m);
    cmd_hour  = W'(h);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".err"}, err, 64'(m_err));
    chk({tag, ".code"}, err_code, 64'(m_code));
    chk({tag, ".acnt"}, alarm_cnt, 64'(m_acnt));
    chk({tag, ".done"}, done, 64'(m_st == 2));
    chk({tag, ".up"}, tmr_up, 64'(m_up));
    chk({tag, ".sec"}, tmr_insec, 64'(m_sec));
    chk({tag, ".min"}, tmr_inmin, 64'(m_min));
    chk({tag, ".hour"}, tmr_inhour, 64'(m_hour));
  endtask

  // RUN command with buzy_n high; watch strobes
  task automatic run_chk(input string tag,
                         input int up, input int s,
                         input int m, input int h);
    int ec;
    int ncut, nwr, nst;
    int cut_at, wr_at, st_at;
    ec = ref_code(up, s, m, h);
    chk({tag, ".rdy"}, cmd_ready, 64'(1));
    send(2'b00, up, s, m, h);
    ncut = 0; nwr = 0; nst = 0;
    cut_at = -1; wr_at = -1; st_at = -1;
    for (int k = 1; k <= 6; k++) begin
      if (tmr_cut_n) begin
        ncut++;
        if (cut_at < 0) cut_at = k;
      end
      if (tmr_write) begin
        nwr++;
        if (wr_at < 0) wr_at = k;
      end
      if (tmr_start) begin
        nst++;
        if (st_at < 0) st_at = k;
      end
      if (k < 6) step();
    end
    if (ec == 0) begin
      m_st = 1; m_err = 0; m_code = 0;
      m_up = up; m_sec = s;
      m_min = m; m_hour = h;
      chk({tag, ".ncut"}, 64'(ncut), 64'(1));
      chk({tag, ".cut@"}, 64'(cut_at), 64'(1));
      chk({tag, ".wr@"}, 64'(wr_at), 64'(3));
      chk({tag, ".st@"}, 64'(st_at), 64'(4));
      chk({tag, ".nwr"}, 64'(nwr), 64'(1));
    end else begin
      m_err = 1; m_code = ec;
      chk({tag, ".ncut"}, 64'(ncut), 64'(0));
      chk({tag, ".nwr"}, 64'(nwr), 64'(0));
      chk({tag, ".nst"}, 64'(nst), 64'(0));
    end
    chk({tag, ".busy"}, busy, 64'(m_st == 1));
    chk_status(tag);
  endtask

  task automatic fire_alarm(input string tag);
    tmr_alarm = 1'b1;
    step();
    tmr_alarm = 1'b0;
    if (m_st == 1) begin
      m_st = 2;
      m_acnt = sat_inc(m_acnt);
    end
    chk({tag, ".adone"}, done, 64'(m_st == 2));
    chk({tag, ".acnt"}, alarm_cnt, 64'(m_acnt));
  endtask

  task automatic model_reset();
    m_st = 0; m_acnt = 0; m_err = 0;
    m_code = 0; m_up = 0; m_sec = 0;
    m_min = 0; m_hour = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nw, nc;
    int s, m, h, up;
    cut_n      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_up     = 1'b0;
    cmd_sec    = '0;
    cmd_min    = '0;
    cmd_hour   = '0;
    tmr_buzy_n = 1'b1;
    tmr_alarm  = 1'b0;
    model_reset();
    #12;
    chk("rst.outs",
        {tmr_cut_n, tmr_write, tmr_start, busy,
         done, err, err_code, alarm_cnt,
         tmr_up, tmr_insec, tmr_inmin,
         tmr_inhour}, 64'(0));
    chk("rst.rdy", cmd_ready, 64'(1));
    #4 cut_n = 1'b1;
    step();

    // 1: basic down-count run, then alarm
    run_chk("t1", 0, 5, 1, 0);
    fire_alarm("t1");

    // 2: range error, then recovery
    run_chk("t2a", 0, 60, 1, 0);
    run_chk("t2b", 0, 3, 2, 0);
    fire_alarm("t2");

    // 3: up-count zero field, then good up run
    run_chk("t3a", 1, 10, 0, 0);
    run_chk("t3b", 1, 10, 1, 1);
    fire_alarm("t3");

    // 4: timer stays busy -> timeout
    tmr_buzy_n = 1'b0;
    send(2'b00, 0, 5, 5, 0);
    m_up = 0; m_sec = 5; m_min = 5; m_hour = 0;
    nb = 0; nw = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      if (tmr_write) nw++;
      step();
    end
    m_st = 0; m_err = 1; m_code = 3;
    chk("t4.busycyc", 64'(nb), 64'(1 + WM));
    chk("t4.nwr", 64'(nw), 64'(0));
    chk("t4.busy", busy, 64'(0));
    chk_status("t4");
    tmr_buzy_n = 1'b1;

    // 5: ABORT and alarm in the same cycle
    run_chk("t5", 0, 30, 2, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    tmr_alarm = 1'b1;
    step();
    cmd_valid = 1'b0;
    tmr_alarm = 1'b0;
    nc = 0; nw = 0;
    for (int k = 0; k < 4; k++) begin
      if (tmr_cut_n) nc++;
      if (tmr_write) nw++;
      step();
    end
    m_st = 0; m_err = 0; m_code = 0;
    chk("t5.ncut", 64'(nc), 64'(1));
    chk("t5.nwr", 64'(nw), 64'(0));
    chk("t5.busy", busy, 64'(0));
    chk_status("t5");

    // reserved op from idle
    send(2'b11, 0, 1, 1, 1);
    m_err = 1; m_code = 3;
    chk("rsvd.busy", busy, 64'(0));
    chk_status("rsvd");

    // random RUN/ALARM/ACK traffic
    for (int it = 0; it < 40; it++) begin
      s  = int'($urandom_range(0, 66));
      m  = int'($urandom_range(0, 66));
      h  = int'($urandom_range(0, 3));
      up = int'($urandom_range(0, 1));
      run_chk("rnd", up, s, m, h);
      if (m_st == 1 || $urandom_range(0, 1) == 1)
        fire_alarm("rnd");
      if (m_st == 2 && $urandom_range(0, 1) == 1)
      begin
        send(2'b10, 0, 0, 0, 0);
        m_st = 0; m_err = 0; m_code = 0;
        chk("rnd.ack.busy", busy, 64'(0));
        chk_status("rnd.ack");
      end
    end

    // 6: async reset during WAIT_FREE
    tmr_buzy_n = 1'b0;
    send(2'b00, 0, 7, 7, 7);
    step();
    step();
    #2 cut_n = 1'b0;
    #1;
    chk("t6.outs",
        {tmr_cut_n, tmr_write, tmr_start, busy,
         done, err, err_code, alarm_cnt,
         tmr_up, tmr_insec, tmr_inmin,
         tmr_inhour}, 64'(0));
    #3 cut_n = 1'b1;
    tmr_buzy_n = 1'b1;
    model_reset();
    step();
    chk("t6.rdy", cmd_ready, 64'(1));
    chk("t6.busy", busy, 64'(0));

    // alarm counter saturation
    for (int r = 0; r < 260; r++) begin
      send(2'b00, 0, 1, 0, 0);
      m_st = 1; m_err = 0; m_code = 0;
      m_up = 0; m_sec = 1; m_min = 0; m_hour = 0;
      for (int k = 0; k < 4; k++) step();
      fire_alarm("sat");
    end
    chk("sat.final", alarm_cnt, 64'(255));
    chk_status("sat");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
